ball_sprite_engine: RTL and testbench

Multi-ball sprite renderer for the VGA pixel path, sitting between the VGA sync generator and the final colour mux. It draws up to N_BALLS circular balls of parametrised diameter. Each ball has its own colour and a rotating seam animation. Ball positions are double-buffered so that a position update never tears a frame. The output is pipelined and registered, and the block reports which ball won each pixel plus a per-frame collision flag.

---
 rtl/vga_pkg.sv | 16 +
 rtl/ball_mask.sv | 42 ++++
 rtl/ball_sprite_engine.sv | 177 +++++++++++++++++
 tb/tb_ball_sprite_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: colour/coordinate widths, named colours and ball position type.
package vga_pkg;

   localparam int unsigned RGB_W   = 12;
   localparam int unsigned COORD_W = 10;

   localparam logic [RGB_W-1:0] BLACK  = 12'h000;
   localparam logic [RGB_W-1:0] ORANGE = 12'hFA0;
   localparam logic [RGB_W-1:0] SEAM   = 12'h420;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } ball_pos_t;

endpackage

// File: rtl/ball_mask.sv
// Combinational circle and rotating-seam test for one ball, from centred odd offsets u/v.
module ball_mask #(
   parameter int unsigned SIZE = 8,
   parameter int unsigned UW   = 5
) (
   input  logic signed [UW-1:0] i_u,
   input  logic signed [UW-1:0] i_v,
   input  logic        [1:0]    i_phase,
   output logic                 o_on,
   output logic                 o_seam
);

   localparam logic [2*UW:0]          R2    = (2*UW+1)'(SIZE * SIZE);
   localparam logic signed [UW-1:0]   P_ONE = UW'(1);
   localparam logic signed [UW-1:0]   M_ONE = UW'(-1);

   logic signed [2*UW-1:0] w_ue, w_ve, w_u2, w_v2;
   logic        [2*UW:0]   w_r2;
   logic                   w_rel;

   assign w_ue = (2*UW)'(i_u);
   assign w_ve = (2*UW)'(i_v);
   assign w_u2 = w_ue * w_ue;
   assign w_v2 = w_ve * w_ve;
   // Squares are non-negative, so the sum can be treated as unsigned.
   assign w_r2 = {1'b0, w_u2} + {1'b0, w_v2};
   assign o_on = (w_r2 <= R2);

   always_comb begin
      w_rel = 1'b0;
      unique case (i_phase)
         2'd0:    w_rel = (i_u == P_ONE) || (i_u == M_ONE);
         2'd1:    w_rel = (i_u == i_v);
         2'd2:    w_rel = (i_v == P_ONE) || (i_v == M_ONE);
         2'd3:    w_rel = (i_u == -i_v);
         default: w_rel = 1'b0;
      endcase
   end

   assign o_seam = o_on & w_rel;

endmodule

// File: rtl/ball_sprite_engine.sv
// Multi-ball sprite renderer: double-buffered positions, 2-stage pixel pipeline, priority mux
// and per-frame collision flag.
module ball_sprite_engine
   import vga_pkg::*;
#(
   parameter int unsigned              N_BALLS  = 2,
   parameter int unsigned              SIZE     = 8,
   parameter int unsigned              ANIM_DIV = 8,
   parameter logic [N_BALLS*RGB_W-1:0] BALL_RGB = {12'h0AF, ORANGE},
   parameter logic [RGB_W-1:0]         SEAM_RGB = SEAM
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_pix_tick,
   input  logic               i_frame_start,
   input  logic               i_video_on,
   input  logic [COORD_W-1:0] i_pixel_x,
   input  logic [COORD_W-1:0] i_pixel_y,
   input  logic               i_pos_we,
   input  logic [1:0]         i_pos_sel,
   input  logic [COORD_W-1:0] i_pos_x,
   input  logic [COORD_W-1:0] i_pos_y,
   input  logic [N_BALLS-1:0] i_chan_en,
   output logic [RGB_W-1:0]   o_object_rgb,
   output logic               o_object_on,
   output logic [1:0]         o_hit_id,
   output logic               o_collision
);

   localparam int unsigned  LOG  = $clog2(SIZE);
   localparam int unsigned  UW   = LOG + 2;
   localparam int unsigned  FCW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [10:0]  HALF = 11'(SIZE / 2);
   localparam logic [10:0]  SZ   = 11'(SIZE);

   ball_pos_t              r_shadow [N_BALLS];
   ball_pos_t              r_active [N_BALLS];
   logic [FCW-1:0]         r_frame_cnt;
   logic [1:0]             r_phase;
   logic                   r_coll_acc, r_collision;

   logic [N_BALLS-1:0]     r_inbox, r_en;
   logic signed [UW-1:0]   r_u [N_BALLS];
   logic signed [UW-1:0]   r_v [N_BALLS];
   logic                   r_vid;

   logic [RGB_W-1:0]       r_rgb;
   logic                   r_on;
   logic [1:0]             r_id;

   logic [N_BALLS-1:0]     w_inbox, w_on, w_seam, w_hit;
   logic signed [UW-1:0]   w_u [N_BALLS];
   logic signed [UW-1:0]   w_v [N_BALLS];
   logic [RGB_W-1:0]       w_rgb;
   logic                   w_obj;
   logic [1:0]             w_id;
   logic                   w_multi, w_coll_now;

   for (genvar g = 0; g < N_BALLS; g++) begin : g_chan
      logic [10:0] w_dx, w_dy;
      // 11-bit offset wraps to a large value left/above the box, so edge clipping is free.
      assign w_dx       = {1'b0, i_pixel_x} - {1'b0, r_active[g].x} + HALF;
      assign w_dy       = {1'b0, i_pixel_y} - {1'b0, r_active[g].y} + HALF;
      assign w_inbox[g] = (w_dx < SZ) && (w_dy < SZ);
      assign w_u[g]     = $signed({1'b0, w_dx[LOG-1:0], 1'b1}) - $signed(UW'(SIZE));
      assign w_v[g]     = $signed({1'b0, w_dy[LOG-1:0], 1'b1}) - $signed(UW'(SIZE));

      ball_mask #(
         .SIZE (SIZE),
         .UW   (UW)
      ) u_ball_mask (
         .i_u     (r_u[g]),
         .i_v     (r_v[g]),
         .i_phase (r_phase),
         .o_on    (w_on[g]),
         .o_seam  (w_seam[g])
      );

      assign w_hit[g] = r_inbox[g] & r_en[g] & w_on[g];
   end

   always_comb begin
      w_rgb = BLACK;
      w_obj = 1'b0;
      w_id  = 2'd0;
      // Descending scan so the lowest-index hit is the last to write.
      for (int i = N_BALLS - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_obj = 1'b1;
            w_id  = 2'(i);
            w_rgb = w_seam[i] ? SEAM_RGB : BALL_RGB[i*RGB_W +: RGB_W];
         end
      end
      if (!r_vid) begin
         w_rgb = BLACK;
         w_obj = 1'b0;
         w_id  = 2'd0;
      end
   end

   assign w_multi    = (w_hit & (w_hit - N_BALLS'(1))) != '0;
   assign w_coll_now = i_pix_tick & r_vid & w_multi;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < N_BALLS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (i_frame_start) begin
            for (int i = 0; i < N_BALLS; i++) r_active[i] <= r_shadow[i];
         end
         if (i_pos_we) begin
            for (int i = 0; i < N_BALLS; i++) begin
               if (i_pos_sel == 2'(i)) r_shadow[i] <= '{x: i_pos_x, y: i_pos_y};
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_frame_cnt <= '0;
         r_phase     <= 2'd0;
      end else if (i_frame_start) begin
         if (r_frame_cnt == FCW'(ANIM_DIV - 1)) begin
            r_frame_cnt <= '0;
            r_phase     <= r_phase + 2'd1;
         end else begin
            r_frame_cnt <= r_frame_cnt + FCW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_inbox <= '0;
         r_en    <= '0;
         r_vid   <= 1'b0;
         for (int i = 0; i < N_BALLS; i++) begin
            r_u[i] <= '0;
            r_v[i] <= '0;
         end
         r_rgb <= BLACK;
         r_on  <= 1'b0;
         r_id  <= 2'd0;
      end else if (i_pix_tick) begin
         r_inbox <= w_inbox;
         r_en    <= i_chan_en;
         r_vid   <= i_video_on;
         r_u     <= w_u;
         r_v     <= w_v;
         r_rgb   <= w_rgb;
         r_on    <= w_obj;
         r_id    <= w_id;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_coll_acc  <= 1'b0;
         r_collision <= 1'b0;
      end else if (i_frame_start) begin
         r_collision <= r_coll_acc;
         r_coll_acc  <= w_coll_now;
      end else if (w_coll_now) begin
         r_coll_acc  <= 1'b1;
      end
   end

   assign o_object_rgb = r_rgb;
   assign o_object_on  = r_on;
   assign o_hit_id     = r_id;
   assign o_collision  = r_collision;

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Directed scoreboard bench for ball_sprite_engine (N_BALLS=2, SIZE=8, ANIM_DIV=2).
module tb_ball_sprite_engine;

   typedef struct packed {
      logic [11:0] rgb;
      logic        on;
      logic [1:0]  id;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_tick, frame_start, video_on, pos_we;
   logic [9:0]  pixel_x, pixel_y, pos_x, pos_y;
   logic [1:0]  pos_sel;
   logic [1:0]  chan_en;
   logic [11:0] object_rgb;
   logic        object_on, collision;
   logic [1:0]  hit_id;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   exp_t last_e;
   int   sh_x[2], sh_y[2], ac_x[2], ac_y[2];
   int   fcnt, ph;
   bit   acc, coll_exp;

   always #5 clk = ~clk;

   ball_sprite_engine #(
      .N_BALLS  (2),
      .SIZE     (8),
      .ANIM_DIV (2)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_pix_tick    (pix_tick),
      .i_frame_start (frame_start),
      .i_video_on    (video_on),
      .i_pixel_x     (pixel_x),
      .i_pixel_y     (pixel_y),
      .i_pos_we      (pos_we),
      .i_pos_sel     (pos_sel),
      .i_pos_x       (pos_x),
      .i_pos_y       (pos_y),
      .i_chan_en     (chan_en),
      .o_object_rgb  (object_rgb),
      .o_object_on   (object_on),
      .o_hit_id      (hit_id),
      .o_collision   (collision)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cmp_out(input exp_t e);
      check("rgb", 32'(object_rgb), 32'(e.rgb));
      check("on", 32'(object_on), 32'(e.on));
      check("hit_id", 32'(hit_id), 32'(e.id));
      check("collision", 32'(collision), 32'(coll_exp));
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         sh_x[c] = 0; sh_y[c] = 0; ac_x[c] = 0; ac_y[c] = 0;
      end
      fcnt = 0; ph = 0; acc = 0; coll_exp = 0;
      q.delete();
   endtask

   task automatic pix(input int x, input int y, input bit vid);
      exp_t e;
      int   hits, dx, dy, u, v;
      bit   s;
      e    = '0;
      hits = 0;
      for (int c = 1; c >= 0; c--) begin
         dx = (x - ac_x[c] + 4) & 'h7FF;
         dy = (y - ac_y[c] + 4) & 'h7FF;
         if (chan_en[c] && dx < 8 && dy < 8) begin
            u = 2 * dx - 7;
            v = 2 * dy - 7;
            if (u * u + v * v <= 64) begin
               hits++;
               case (ph)
                  0:       s = (u == 1) || (u == -1);
                  1:       s = (u == v);
                  2:       s = (v == 1) || (v == -1);
                  default: s = (u == -v);
               endcase
               e.on  = 1'b1;
               e.id  = 2'(c);
               e.rgb = s ? 12'h420 : ((c == 0) ? 12'hFA0 : 12'h0AF);
            end
         end
      end
      if (!vid) e = '0;
      else if (hits >= 2) acc = 1;
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = vid;
      pix_tick = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      pix_tick = 1'b0;
      if (q.size() == 2) begin
         last_e = q.pop_front();
         cmp_out(last_e);
      end
   endtask

   task automatic model_frame();
      for (int c = 0; c < 2; c++) begin
         ac_x[c] = sh_x[c];
         ac_y[c] = sh_y[c];
      end
      coll_exp = acc;
      acc      = 0;
      if (fcnt == 1) begin
         fcnt = 0;
         ph   = (ph + 1) % 4;
      end else begin
         fcnt++;
      end
   endtask

   // Blank pixels drain the pipeline so no drawn pixel straddles a frame boundary.
   task automatic write_pos(input int sel, input int x, input int y, input bit with_fs);
      pix(0, 0, 0);
      pix(0, 0, 0);
      pos_we      = 1'b1;
      pos_sel     = 2'(sel);
      pos_x       = 10'(x);
      pos_y       = 10'(y);
      frame_start = with_fs;
      @(posedge clk);
      #1;
      pos_we      = 1'b0;
      frame_start = 1'b0;
      if (with_fs) model_frame();
      if (sel < 2) begin
         sh_x[sel] = x;
         sh_y[sel] = y;
      end
   endtask

   task automatic frame();
      pix(0, 0, 0);
      pix(0, 0, 0);
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      model_frame();
      check("collision_at_frame", 32'(collision), 32'(coll_exp));
   endtask

   task automatic sweep(input int x0, input int x1, input int y0, input int y1, input bit vid);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) pix(x, y, vid);
   endtask

   initial begin
      reset_n = 1'b0; pix_tick = 1'b0; frame_start = 1'b0; video_on = 1'b0;
      pos_we = 1'b0; pos_sel = 2'd0; pos_x = '0; pos_y = '0;
      pixel_x = '0; pixel_y = '0; chan_en = 2'b01;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'(object_rgb), 32'h0);
      check("rst_on", 32'(object_on), 32'h0);
      check("rst_id", 32'(hit_id), 32'h0);
      check("rst_coll", 32'(collision), 32'h0);
      reset_n = 1'b1;

      // Basic draw
      write_pos(0, 100, 100, 0);
      frame();
      sweep(96, 103, 96, 103, 1);
      pix(100, 100, 1);
      pix(0, 0, 0);
      check("seam_p0_center", 32'(object_rgb), 32'h420);

      // Double buffering, including write in the same clk as frame_start
      write_pos(0, 200, 50, 0);
      pix(100, 100, 1); pix(200, 50, 1); pix(0, 0, 0);
      frame();
      pix(200, 50, 1); pix(100, 100, 1); pix(0, 0, 0);
      write_pos(0, 300, 300, 0);
      write_pos(0, 100, 100, 1);
      pix(300, 300, 1); pix(100, 100, 1); pix(0, 0, 0);
      check("dbuf_old_used_off", 32'(object_on), 32'h0);
      frame();
      pix(300, 300, 1); pix(100, 100, 1); pix(0, 0, 0);

      // Edge clip
      write_pos(0, 2, 2, 0);
      write_pos(3, 500, 500, 0);
      frame();
      sweep(0, 5, 0, 5, 1);
      sweep(1020, 1023, 0, 3, 1);
      pix(0, 0, 0);
      check("edge_x1023_off", 32'(object_on), 32'h0);

      // Priority and collision
      chan_en = 2'b11;
      write_pos(0, 100, 100, 0);
      write_pos(1, 103, 100, 0);
      frame();
      sweep(95, 108, 98, 102, 1);
      pix(101, 100, 1); pix(0, 0, 0);
      check("overlap_id", 32'(hit_id), 32'h0);
      write_pos(1, 200, 200, 0);
      frame();
      check("collision_set", 32'(collision), 32'h1);
      sweep(96, 104, 100, 100, 1);
      pix(200, 200, 1);
      frame();
      check("collision_clear", 32'(collision), 32'h0);

      // Animation: phase steps every second frame
      chan_en = 2'b01;
      for (int f = 0; f < 9; f++) begin
         frame();
         pix(100, 100, 1); pix(101, 100, 1); pix(100, 101, 1);
         pix(99, 99, 1); pix(102, 102, 1); pix(98, 101, 1);
      end

      // Outputs hold while pix_tick is low
      pix(100, 100, 1);
      pix(101, 100, 1);
      pixel_x = 10'd500; pixel_y = 10'd500; video_on = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp_out(last_e);

      // Blanking over overlapping balls: no draw, no collision
      chan_en = 2'b11;
      write_pos(1, 103, 100, 0);
      frame();
      sweep(96, 106, 99, 101, 0);
      frame();
      check("blank_no_collision", 32'(collision), 32'h0);

      // Asynchronous reset mid-line
      sweep(96, 100, 100, 100, 1);
      pix_tick = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_rgb", 32'(object_rgb), 32'h0);
      check("arst_on", 32'(object_on), 32'h0);
      check("arst_id", 32'(hit_id), 32'h0);
      check("arst_coll", 32'(collision), 32'h0);
      pix_tick = 1'b0;
      model_reset();
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      sweep(0, 3, 0, 3, 1);
      pix(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
